demux_buffer_1x2: RTL and testbench
===================================

DEMUX_BUFFER_1X2 -- requirements
Module: demux_buffer_1x2

Interface
REQ-001 Parameter WIDTH, default 2, data width in bits.
REQ-002 Parameter DEPTH, default 4, entries per output FIFO; power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_L  input  1  reset, asynchronous, active-low.
REQ-005 Port selector  input  1  routing select; 0 routes to channel 0, 1 routes to channel 1.
REQ-006 Port valid_in  input  1  data_in is valid this cycle.
REQ-007 Port data_in  input  WIDTH  incoming word from the upstream 2:1 mux stage.
REQ-008 Port pop0, pop1  input  1 each  consumer read request, per channel.
REQ-009 Port data_out0, data_out1  output  WIDTH each  registered read data, per channel.
REQ-010 Port valid_out0, valid_out1  output  1 each  data_outN carries a popped word this cycle.
REQ-011 Port empty0, empty1, full0, full1  output  1 each  FIFO status, combinational from occupancy count.
REQ-012 Port almost_full0, almost_full1  output  1 each  count >= DEPTH-1; upstream backpressure.
REQ-013 Port overflow  output  1  sticky; a push was dropped on either channel.

Function
REQ-014 Push to FIFO N (N = selector) SHALL occur on the clock edge where valid_in=1 and the push is accepted.
REQ-015 A push SHALL be accepted when FIFO N is not full, or when FIFO N is full and popN is accepted on the same edge.
REQ-016 A rejected push SHALL drop the word, leave FIFO N unchanged, and set overflow.
REQ-017 A pop on channel N SHALL be accepted when popN=1 and emptyN=0; popN while empty SHALL be ignored without error.
REQ-018 An accepted pop SHALL load the head word into data_outN and set valid_outN=1 for exactly one cycle.
REQ-019 When no pop is accepted, valid_outN SHALL be 0 and data_outN SHALL hold its last value.
REQ-020 Latency: a word pushed at edge k SHALL clear emptyN after edge k, be poppable at edge k+1, and appear on data_outN after edge k+1.
REQ-021 No bypass: push and pop at the same edge on an empty FIFO SHALL store the word; the pop SHALL be ignored.
REQ-022 Simultaneous accepted push and pop on one FIFO SHALL leave its count unchanged.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 Count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH; emptyN = (count==0), fullN = (count==DEPTH).
REQ-025 The two channels SHALL operate independently; a pop on one channel SHALL NOT affect the other.
REQ-026 overflow SHALL remain 1 until reset.
REQ-027 FIFO order SHALL be strict first-in first-out per channel.

Reset
REQ-028 reset_L=0 SHALL immediately, without waiting for clk, clear pointers, counts, data_out0/1, valid_out0/1, and overflow.
REQ-029 After reset: empty0=empty1=1, full0=full1=0, almost_full0=almost_full1=0.
REQ-030 FIFO storage arrays SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words; the first edge after release SHALL be treated as empty.

Structure
REQ-032 Shared package demux_pkg SHALL hold the WIDTH and DEPTH defaults and the derived pointer and count widths.
REQ-033 Each channel SHALL be one instance of sub-module fifo_sync (push, pop, din, dout, valid, empty, full, almost_full, drop); the top contains routing and the overflow OR only.

Verification
REQ-034 Reset, then push 2'b01 (sel=0) and 2'b10 (sel=1), then pop0 and pop1 -> data_out0=01 and data_out1=10 with valid_out0/1=1 two edges after the push.
REQ-035 Push 4 words 00,01,10,11 to ch0 -> full0=1 and almost_full0=1 at count 3; a fifth push 00 is dropped and overflow=1; pops return 00,01,10,11 in order.
REQ-036 ch0 full, then push 2'b10 and pop0 at the same edge -> push accepted, count stays 4, overflow stays 0, last pop returns 10.
REQ-037 ch1 empty, push 2'b11 and pop1 at the same edge -> valid_out1=0 that cycle, empty1=0 afterwards, next pop returns 11.
REQ-038 Fill ch1 with 3 words, assert reset_L=0 between edges -> valid_out1=0 and empty1=1 immediately; after release, pop1 yields valid_out1=0.
REQ-039 Interleave 10 pushes alternating selector with continuous pops on both channels -> pointer wrap verified, per-channel order preserved, overflow=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared defaults and derived widths for the 1:2 demux buffer and its per-channel FIFOs.
package demux_pkg;

  localparam int unsigned WIDTH_DEF = 2;
  localparam int unsigned DEPTH_DEF = 4;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned PTR_W_DEF = ptr_w(DEPTH_DEF);
  localparam int unsigned CNT_W_DEF = PTR_W_DEF + 1;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read port, no write-to-read bypass, and drop reporting.
module fifo_sync
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             drop
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             pop_ok;
  logic             push_ok;

  // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    drop    = push && !push_ok;
  end

  assign empty       = (cnt == '0);
  assign full        = (cnt == FULL_CNT);
  assign almost_full = (cnt >= AF_CNT);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= pop_ok;
      if (pop_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/demux_buffer_1x2.sv
// Routes the upstream mux stream into one of two independent FIFOs; flags any dropped push.
module demux_buffer_1x2
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             selector,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop0,
  input  logic             pop1,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             empty0,
  output logic             empty1,
  output logic             full0,
  output logic             full1,
  output logic             almost_full0,
  output logic             almost_full1,
  output logic             overflow
);

  logic push0;
  logic push1;
  logic drop0;
  logic drop1;

  assign push0 = valid_in && !selector;
  assign push1 = valid_in && selector;

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push0),
    .pop         (pop0),
    .din         (data_in),
    .dout        (data_out0),
    .valid       (valid_out0),
    .empty       (empty0),
    .full        (full0),
    .almost_full (almost_full0),
    .drop        (drop0)
  );

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push1),
    .pop         (pop1),
    .din         (data_in),
    .dout        (data_out1),
    .valid       (valid_out1),
    .empty       (empty1),
    .full        (full1),
    .almost_full (almost_full1),
    .drop        (drop1)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      overflow <= 1'b0;
    end else if (drop0 || drop1) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_buffer_1x2.sv
// Bench for demux_buffer_1x2: directed scenarios plus random traffic against a queue model.
module tb_demux_buffer_1x2;

  localparam int W = 2;
  localparam int D = 4;
  typedef logic [8+2*W:0] vec_t;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         selector = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         pop0 = 1'b0;
  logic         pop1 = 1'b0;
  logic [W-1:0] data_out0, data_out1;
  logic         valid_out0, valid_out1, empty0, empty1, full0, full1;
  logic         almost_full0, almost_full1, overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per channel plus last-popped words and sticky drop flag.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] m_d0 = '0, m_d1 = '0;
  logic         m_v0 = 1'b0, m_v1 = 1'b0, m_ovf = 1'b0;

  demux_buffer_1x2 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .selector     (selector),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .pop0         (pop0),
    .pop1         (pop1),
    .data_out0    (data_out0),
    .data_out1    (data_out1),
    .valid_out0   (valid_out0),
    .valid_out1   (valid_out1),
    .empty0       (empty0),
    .empty1       (empty1),
    .full0        (full0),
    .full1        (full1),
    .almost_full0 (almost_full0),
    .almost_full1 (almost_full1),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t exp_vec();
    return {m_v0, m_v1, q0.size() == 0, q1.size() == 0, q0.size() == D, q1.size() == D,
            q0.size() >= D - 1, q1.size() >= D - 1, m_ovf, m_d0, m_d1};
  endfunction

  function automatic vec_t dut_vec();
    return {valid_out0, valid_out1, empty0, empty1, full0, full1,
            almost_full0, almost_full1, overflow, data_out0, data_out1};
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_d0 = '0; m_d1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #3;
    model_reset();
    reset_L = 1'b1;
    #1;
  endtask

  // Drives one cycle of inputs, lets the edge happen, advances the model, settles 1 time unit past the edge.
  task automatic cycle(input logic sel, input logic vin, input logic [W-1:0] din,
                       input logic p0, input logic p1);
    logic pk0, pk1, pop_sel;
    int   n_sel;
    selector = sel; valid_in = vin; data_in = din; pop0 = p0; pop1 = p1;
    @(posedge clk);
    pk0     = p0 && (q0.size() > 0);
    pk1     = p1 && (q1.size() > 0);
    n_sel   = sel ? q1.size() : q0.size();
    pop_sel = sel ? pk1 : pk0;
    m_v0 = pk0;
    m_v1 = pk1;
    if (pk0) m_d0 = q0.pop_front();
    if (pk1) m_d1 = q1.pop_front();
    if (vin) begin
      if (n_sel < D || pop_sel) begin
        if (sel) q1.push_back(din); else q0.push_back(din);
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
    valid_in = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
  endtask

  task automatic test_reset();
    vec_t want;
    reset_L = 1'b0;
    #2;
    want = {9'b001100000, {(2*W){1'b0}}};
    checks++;
    if (dut_vec() !== want)
      $display("FAIL reset_state: got %h expected %h", dut_vec(), want);
    if (dut_vec() !== want) errors++;
    do_reset();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    checks++;
    if (empty0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty0_cleared: got %b expected 0", empty0);
    end
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    checks++;
    if ({valid_out0, data_out0, valid_out1, data_out1} !== {1'b1, 2'b01, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL basic_pop: got v0=%b d0=%b v1=%b d1=%b expected v0=1 d0=01 v1=1 d1=10",
               valid_out0, data_out0, valid_out1, data_out1);
    end
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checks++;
    if ({valid_out0, data_out0, valid_out1, data_out1} !== {1'b0, 2'b01, 1'b0, 2'b10}) begin
      errors++;
      $display("FAIL basic_hold: got v0=%b d0=%b v1=%b d1=%b expected v0=0 d0=01 v1=0 d1=10",
               valid_out0, data_out0, valid_out1, data_out1);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] w;
    do_reset();
    for (int i = 0; i < D; i++) begin
      w = W'(i);
      cycle(1'b0, 1'b1, w, 1'b0, 1'b0);
      if (i == D - 2) begin
        checks++;
        if ({almost_full0, full0} !== 2'b10) begin
          errors++;
          $display("FAIL fill_almost_full: got af=%b full=%b expected af=1 full=0", almost_full0, full0);
        end
      end
    end
    checks++;
    if ({almost_full0, full0, overflow} !== 3'b110) begin
      errors++;
      $display("FAIL fill_full: got af=%b full=%b ovf=%b expected 1 1 0", almost_full0, full0, overflow);
    end
    cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    checks++;
    if ({overflow, full0} !== 2'b11) begin
      errors++;
      $display("FAIL fill_overflow: got ovf=%b full=%b expected 1 1", overflow, full0);
    end
    for (int i = 0; i < D; i++) begin
      w = W'(i);
      cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      checks++;
      if ({valid_out0, data_out0} !== {1'b1, w}) begin
        errors++;
        $display("FAIL fill_order[%0d]: got v=%b d=%b expected v=1 d=%b", i, valid_out0, data_out0, w);
      end
    end
    checks++;
    if ({empty0, overflow} !== 2'b11) begin
      errors++;
      $display("FAIL fill_drained: got empty=%b ovf=%b expected 1 1", empty0, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] want [4];
    do_reset();
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, W'(i), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    checks++;
    if ({valid_out0, data_out0, full0, overflow} !== {1'b1, 2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fullpp_same_edge: got v=%b d=%b full=%b ovf=%b expected 1 00 1 0",
               valid_out0, data_out0, full0, overflow);
    end
    want = '{2'b01, 2'b10, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      checks++;
      if ({valid_out0, data_out0} !== {1'b1, want[i]}) begin
        errors++;
        $display("FAIL fullpp_pop[%0d]: got v=%b d=%b expected v=1 d=%b", i, valid_out0, data_out0, want[i]);
      end
    end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
    checks++;
    if ({valid_out1, empty1} !== 2'b00) begin
      errors++;
      $display("FAIL nobypass: got v1=%b empty1=%b expected 0 0", valid_out1, empty1);
    end
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checks++;
    if ({valid_out1, data_out1} !== {1'b1, 2'b11}) begin
      errors++;
      $display("FAIL nobypass_pop: got v1=%b d1=%b expected 1 11", valid_out1, data_out1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    checks++;
    if ({valid_out1, data_out1} !== {1'b1, 2'b01}) begin
      errors++;
      $display("FAIL areset_pre: got v1=%b d1=%b expected 1 01", valid_out1, data_out1);
    end
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({valid_out1, empty1, data_out1} !== {1'b0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL areset_immediate: got v1=%b empty1=%b d1=%b expected 0 1 00",
               valid_out1, empty1, data_out1);
    end
    model_reset();
    #1;
    reset_L = 1'b1;
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checks++;
    if ({valid_out1, empty1} !== 2'b01) begin
      errors++;
      $display("FAIL areset_pop_after: got v1=%b empty1=%b expected 0 1", valid_out1, empty1);
    end
  endtask

  task automatic test_interleave();
    do_reset();
    for (int i = 0; i < 10 + 3; i++) begin
      cycle(i[0], i < 10, W'($urandom), 1'b1, 1'b1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL interleave[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if ({overflow, empty0, empty1} !== 3'b011) begin
      errors++;
      $display("FAIL interleave_end: got ovf=%b e0=%b e1=%b expected 0 1 1", overflow, empty0, empty1);
    end
  endtask

  task automatic test_random();
    int unsigned push_pct, pop_pct;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset();
      push_pct = (i % 50 < 25) ? 85 : 40;
      pop_pct  = (i % 50 < 25) ? 25 : 75;
      cycle($urandom_range(1, 0) == 1, $urandom_range(99, 0) < push_pct, W'($urandom),
            $urandom_range(99, 0) < pop_pct, $urandom_range(99, 0) < pop_pct);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_push_pop();
    test_empty_push_pop();
    test_async_reset();
    test_interleave();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
